// File: rtl/cache_top_pkg.sv
// Shared fetch-path types (ariane-style frontend request/response) and cache FSM states.
package cache_top_pkg;
  localparam int VLEN        = 32;
  localparam int FETCH_WIDTH = 32;

  typedef struct packed {
    logic            valid;
    logic [31:0]     cause;
    logic [VLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            req;
    logic            kill_s1;
    logic            kill_s2;
    logic            spec;
    logic [VLEN-1:0] vaddr;
  } icache_dreq_i_t;

  typedef struct packed {
    logic                   ready;
    logic                   valid;
    logic [FETCH_WIDTH-1:0] data;
    logic [VLEN-1:0]        vaddr;
    exception_t             ex;
  } icache_dreq_o_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    REFILL
  } state_e;
endpackage

// File: rtl/cache_top_if.sv
// Fetch request/response bundle between a stimulus source and the cache.
interface icache_if
  import cache_top_pkg::*;
(
  input logic clk_i,
  input logic rst_ni
);
  icache_dreq_i_t dreq_i;
  icache_dreq_o_t dreq_o;

  modport master (input clk_i, input rst_ni, output dreq_i, input dreq_o);
  modport slave  (output dreq_o, input dreq_i);
endinterface

// File: rtl/cache_top_mem.sv
// Backing instruction memory. Word i holds i<<2, so the contents are computed
// from the wrapped word address rather than stored.
module icache_mem_model
  import cache_top_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic [VLEN-1:0] addr,
  output logic [31:0]     rdata
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [AW-1:0] waddr;
  logic          unused_bits;

  assign waddr       = addr[AW+1:2];
  assign rdata       = 32'(waddr) << 2;
  assign unused_bits = ^{addr[VLEN-1:AW+2], addr[1:0]};
endmodule

// File: rtl/cache_top.sv
// Direct-mapped instruction cache with an internal backing memory; single
// outstanding request, refill one word per cycle after a fixed miss delay.
module cache_top
  import cache_top_pkg::*;
#(
  parameter int NUM_LINES    = 16,
  parameter int LINE_BYTES   = 16,
  parameter int MEM_WORDS    = 1024,
  parameter int MISS_LATENCY = 4
) (
  input logic     clk_i,
  input logic     rst_ni,
  icache_if.slave bus
);
  localparam int OFFSET_W     = $clog2(LINE_BYTES);
  localparam int INDEX_W      = $clog2(NUM_LINES);
  localparam int TAG_W        = VLEN - OFFSET_W - INDEX_W;
  localparam int REFILL_WORDS = LINE_BYTES / 4;
  localparam int RCNT_W       = (REFILL_WORDS > 1) ? $clog2(REFILL_WORDS) : 1;
  localparam int CNT_W        = $clog2(MISS_LATENCY + 1);

  state_e state_q, state_d;

  logic [VLEN-1:0]   vaddr_q;
  logic              killed_q;
  logic [CNT_W-1:0]  wait_q;
  logic [RCNT_W-1:0] rcnt_q;

  logic [NUM_LINES-1:0]                        valid_q;
  logic [NUM_LINES-1:0][TAG_W-1:0]             tag_q;
  logic [NUM_LINES-1:0][REFILL_WORDS-1:0][31:0] data_q;

  logic [31:0]     data_out_q;
  logic [VLEN-1:0] vaddr_out_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [RCNT_W-1:0]  wsel;
  logic               hit, kill_now, accept, fire, last_word;
  logic [VLEN-1:0]    refill_addr;
  logic [31:0]        mem_word, line_word;
  logic               unused_spec;

  assign idx         = vaddr_q[OFFSET_W +: INDEX_W];
  assign tag         = vaddr_q[VLEN-1 -: TAG_W];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign kill_now    = bus.dreq_i.kill_s1 | bus.dreq_i.kill_s2;
  assign accept      = (state_q == IDLE) && bus.dreq_i.req && !kill_now;
  assign last_word   = (rcnt_q == RCNT_W'(REFILL_WORDS - 1));
  assign line_word   = data_q[idx][wsel];
  assign unused_spec = bus.dreq_i.spec;

  generate
    if (REFILL_WORDS > 1) begin : g_wsel
      assign wsel = vaddr_q[2 +: RCNT_W];
    end else begin : g_wsel_one
      assign wsel = '0;
    end
  endgenerate

  assign refill_addr = {vaddr_q[VLEN-1:OFFSET_W], OFFSET_W'(0)} | VLEN'({rcnt_q, 2'b00});

  icache_mem_model #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .addr  (refill_addr),
    .rdata (mem_word)
  );

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          fire    = !killed_q && !kill_now;
          state_d = IDLE;
        end else if (killed_q || kill_now) begin
          state_d = IDLE;
        end else begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: if (wait_q == CNT_W'(1)) state_d = REFILL;
      // A killed refill still installs the line but does not re-run the lookup.
      REFILL:    if (last_word) state_d = (killed_q || kill_now) ? IDLE : LOOKUP;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vaddr_q     <= '0;
      killed_q    <= 1'b0;
      wait_q      <= '0;
      rcnt_q      <= '0;
      valid_q     <= '0;
      data_out_q  <= '0;
      vaddr_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vaddr_q  <= bus.dreq_i.vaddr;
        killed_q <= 1'b0;
      end else if (state_q != IDLE && kill_now) begin
        killed_q <= 1'b1;
      end
      if (state_q == LOOKUP && !hit) begin
        wait_q       <= CNT_W'(MISS_LATENCY);
        valid_q[idx] <= 1'b0;
      end
      if (state_q == MISS_WAIT) begin
        wait_q <= wait_q - CNT_W'(1);
        rcnt_q <= '0;
      end
      if (state_q == REFILL) begin
        rcnt_q <= rcnt_q + RCNT_W'(1);
        if (last_word) valid_q[idx] <= 1'b1;
      end
      if (fire) begin
        data_out_q  <= line_word;
        vaddr_out_q <= vaddr_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == REFILL) begin
      data_q[idx][rcnt_q] <= mem_word;
      if (last_word) tag_q[idx] <= tag;
    end
  end

  always_comb begin
    bus.dreq_o       = '0;
    bus.dreq_o.ready = rst_ni && (state_q == IDLE);
    bus.dreq_o.valid = fire;
    bus.dreq_o.data  = fire ? line_word : data_out_q;
    bus.dreq_o.vaddr = fire ? vaddr_q : vaddr_out_q;
  end
endmodule

// File: tb/tb_cache_top.sv
// Directed + randomized fetch traffic against a line-presence model of the cache.
module tb_cache_top;
  import cache_top_pkg::*;

  localparam int NUM_LINES    = 16;
  localparam int LINE_BYTES   = 16;
  localparam int MEM_WORDS    = 1024;
  localparam int MISS_LATENCY = 4;
  localparam int LAT_MISS     = 1 + MISS_LATENCY + LINE_BYTES / 4 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_if bus (.clk_i(clk), .rst_ni(rst_n));

  cache_top #(
    .NUM_LINES(NUM_LINES), .LINE_BYTES(LINE_BYTES),
    .MEM_WORDS(MEM_WORDS), .MISS_LATENCY(MISS_LATENCY)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: which line number (vaddr / LINE_BYTES) each index currently holds.
  bit          mv [NUM_LINES];
  logic [31:0] ml [NUM_LINES];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return ((a >> 2) % MEM_WORDS) << 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = (a / LINE_BYTES) % NUM_LINES;
    return mv[idx] && (ml[idx] == a / LINE_BYTES);
  endfunction

  // kill_k: cycle after acceptance (1 = lookup cycle) in which a kill is pulsed; 0 = none.
  task automatic run_req(input logic [31:0] a, input int kill_k, input int kill_sel);
    bit hit;
    int lat, ready_k, idx;
    hit     = model_hit(a);
    idx     = (a / LINE_BYTES) % NUM_LINES;
    lat     = hit ? 1 : LAT_MISS;
    ready_k = (!hit && kill_k >= 2 && kill_k < LAT_MISS) ? LAT_MISS : lat + 1;
    @(negedge clk);
    bus.dreq_i       = '0;
    bus.dreq_i.req   = 1'b1;
    bus.dreq_i.vaddr = a;
    #1 chk("ready_before_req", 64'(bus.dreq_o.ready), 64'(1));
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.dreq_i.req     = 1'b0;
      bus.dreq_i.kill_s1 = (k == kill_k) && (kill_sel == 1);
      bus.dreq_i.kill_s2 = (k == kill_k) && (kill_sel == 2);
      #1;
      chk($sformatf("valid a=%0h k=%0d", a, k), 64'(bus.dreq_o.valid), 64'(kill_k == 0 && k == lat));
      chk($sformatf("ready a=%0h k=%0d", a, k), 64'(bus.dreq_o.ready), 64'(k >= ready_k));
      if (kill_k == 0 && k == lat) begin
        chk($sformatf("data a=%0h", a), 64'(bus.dreq_o.data), 64'(exp_word(a)));
        chk($sformatf("vaddr a=%0h", a), 64'(bus.dreq_o.vaddr), 64'(a));
        chk("ex", 64'(bus.dreq_o.ex), 64'(0));
      end
    end
    bus.dreq_i = '0;
    if (!hit) begin
      mv[idx] = 1'b1;
      ml[idx] = a / LINE_BYTES;
    end
  endtask

  logic [31:0] pool [6];

  initial begin
    logic [31:0] a;
    int kk;
    bus.dreq_i = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      mv[i] = 1'b0;
      ml[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.dreq_o.ready), 64'(0));
    chk("rst_valid", 64'(bus.dreq_o.valid), 64'(0));
    chk("rst_data",  64'(bus.dreq_o.data),  64'(0));
    chk("rst_vaddr", 64'(bus.dreq_o.vaddr), 64'(0));
    chk("rst_ex",    64'(bus.dreq_o.ex),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_req(32'h40, 0, 0);     // cold miss
    run_req(32'h44, 0, 0);     // same line hit
    run_req(32'h1040, 0, 0);   // alias, memory wraps
    run_req(32'h40, 0, 0);     // evicted, misses again
    run_req(32'h80, 3, 2);     // kill_s2 in MISS_WAIT
    run_req(32'h84, 0, 0);     // line installed despite kill
    run_req(32'h84, 1, 1);     // kill on hit lookup

    // Request with kill in the same cycle is not accepted.
    @(negedge clk);
    bus.dreq_i.req     = 1'b1;
    bus.dreq_i.kill_s1 = 1'b1;
    bus.dreq_i.vaddr   = 32'h100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.dreq_i = '0;
      #1;
      chk($sformatf("rejkill_ready k=%0d", k), 64'(bus.dreq_o.ready), 64'(1));
      chk($sformatf("rejkill_valid k=%0d", k), 64'(bus.dreq_o.valid), 64'(0));
    end
    run_req(32'h100, 0, 0);    // full miss proves nothing was fetched

    // Reset in the middle of a refill of 0x200.
    @(negedge clk);
    bus.dreq_i.req   = 1'b1;
    bus.dreq_i.vaddr = 32'h200;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.dreq_i = '0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.dreq_o.ready), 64'(0));
    chk("midrst_valid", 64'(bus.dreq_o.valid), 64'(0));
    chk("midrst_data",  64'(bus.dreq_o.data),  64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_LINES; i++) mv[i] = 1'b0;
    run_req(32'h200, 0, 0);
    run_req(32'h100, 0, 0);    // cache was flushed by reset

    pool[0] = 32'h40;  pool[1] = 32'h80;   pool[2] = 32'h1040;
    pool[3] = 32'h2080; pool[4] = 32'h300; pool[5] = 32'h3C0;
    for (int i = 0; i < 40; i++) begin
      a = pool[$urandom_range(0, 5)] + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      if (model_hit(a)) kk = ($urandom_range(0, 9) == 0) ? 1 : 0;
      else              kk = ($urandom_range(0, 3) == 0) ? $urandom_range(2, LAT_MISS) : 0;
      run_req(a, kk, $urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
